fifo_unpack: RTL and testbench
==============================

Name: fifo_unpack

Overview:
- Read-side companion to the word FIFO: accepts one packed quad-word per handshake and emits its words one at a time, lowest word first, on a valid/ready stream.
- Sits between a quad-word wide producer (the FIFO pop port / qword datapath) and word-wide consumers.
- Supports partial quad-words (word count per beat) and a frame-last marker.
- Sustains one output word per cycle across back-to-back input beats.

Parameters:
- WordWidth, 32, bits per word (matches word_t).
- NumWords, 4, words per packed input beat (matches qword_t); must be >= 2.
- CntWidth, $clog2(NumWords+1), width of word-count field; derived, not to be overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- flush_i  input  1  synchronous discard of any held beat.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat accepted when in_valid_i && in_ready_o.
- in_data_i  input  NumWords*WordWidth  packed words; word k = bits [k*WordWidth +: WordWidth].
- in_cnt_i  input  CntWidth  number of valid words in beat, 1..NumWords.
- in_last_i  input  1  beat ends a frame.
- out_valid_o  output  1  output word valid.
- out_ready_i  input  1  consumer ready.
- out_data_o  output  WordWidth  current word.
- out_last_o  output  1  current word is the final word of a last beat.
- busy_o  output  1  a beat is held (== out_valid_o).

Behaviour:
- Reset (rst_ni low, async): held-valid flag 0, index 0, count 0, last 0, data 0. Outputs: out_valid_o 0, out_data_o 0, out_last_o 0, busy_o 0, in_ready_o 1 (combinational, see below; flush_i low).
- States: EMPTY (no beat held) and DRAIN (beat held, index idx in 0..cnt-1).
- in_ready_o = !flush_i && (EMPTY || (out_ready_i && idx == cnt-1)). Combinational from out_ready_i; no combinational path from in_valid_i to out_*.
- Accept at edge t: register data, cnt, last; set idx = 0; enter DRAIN. Word 0 is visible at out_data_o from t+1 (latency 1 cycle).
- DRAIN: out_valid_o = 1; out_data_o = word[idx]; out_last_o = last_q && (idx == cnt_q-1).
- On out handshake with idx < cnt_q-1: idx increments.
- On out handshake with idx == cnt_q-1:
  - If an input beat is accepted the same cycle, load it and set idx = 0 (zero-bubble throughput).
  - Otherwise go to EMPTY.
- in_cnt_i == 0 or > NumWords: clamped to NumWords at capture.
- Words at index >= cnt are never emitted.
- Without a handshake (out_valid_o && !out_ready_i), out_data_o and out_last_o hold stable; AXI-style, valid never drops before a handshake except on flush/reset.
- flush_i (synchronous, highest priority):
  - Next state EMPTY, idx 0; the current out handshake, if any, still counts as delivered that cycle.
  - in_ready_o is forced 0, so no beat is accepted in a flush cycle.
- Reset mid-DRAIN: held beat discarded immediately; no partial words emitted after reset release.
- Throughput: a full beat yields NumWords words in NumWords cycles; consecutive beats stream without gaps when out_ready_i is held high.

Test Plan:
- Single full beat, in_data_i = 0x44444444_33333333_22222222_11111111, cnt 4, last 1, out_ready_i = 1 -> out_data_o 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles t+1..t+4; out_last_o high only on 0x44444444; in_ready_o high again at t+4.
- Two back-to-back full beats with out_ready_i = 1 -> 8 consecutive output cycles with no bubble; second beat accepted in the same cycle word 3 of the first beat is popped.
- Partial beat, cnt 2, data words 0xA, 0xB, 0xC, 0xD, last 0 -> only 0xA, 0xB emitted; out_last_o never high; in_ready_o = 1 in the cycle 0xB is popped.
- Backpressure: out_ready_i toggles 1, 0, 0, 1, 1, 1 -> each word is held stable while stalled; all 4 words delivered in order; in_ready_o stays 0 until the final pop.
- flush_i asserted for one cycle while idx = 1 with in_valid_i = 1 -> in_ready_o 0 that cycle; out_valid_o 0 the next cycle; a new beat is accepted on the following cycle and starts at its word 0.
- in_cnt_i = 0 -> treated as 4 and all four words emitted; async reset pulse mid-drain -> out_valid_o drops immediately and in_ready_o = 1 after release.

Source files
------------

// File: rtl/fifo_unpack.sv
// Quad-word to word unpacker: holds one packed beat and streams its valid words
// lowest first, reloading on the final pop so back-to-back beats have no bubble.
module fifo_unpack #(
  parameter int WordWidth = 32,
  parameter int NumWords  = 4,
  parameter int CntWidth  = $clog2(NumWords+1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NumWords*WordWidth-1:0] in_data_i,
  input  logic [CntWidth-1:0]           in_cnt_i,
  input  logic                          in_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [WordWidth-1:0]          out_data_o,
  output logic                          out_last_o,
  output logic                          busy_o
);

  localparam int IdxWidth = $clog2(NumWords);

  typedef enum logic {EMPTY, DRAIN} state_e;

  state_e                             state_q, state_d;
  logic [IdxWidth-1:0]                idx_q, idx_d;
  logic [IdxWidth-1:0]                lidx_q, lidx_in;
  logic [NumWords-1:0][WordWidth-1:0] data_q;
  logic                               last_q;
  logic                               at_end, accept, pop, load;

  // Store the index of the final word rather than the count; out-of-range
  // counts collapse to a full beat.
  always_comb begin
    lidx_in = IdxWidth'(NumWords - 1);
    if (in_cnt_i != '0 && in_cnt_i <= CntWidth'(NumWords))
      lidx_in = IdxWidth'(in_cnt_i - CntWidth'(1));
  end

  assign at_end      = (idx_q == lidx_q);
  assign out_valid_o = (state_q == DRAIN);
  assign busy_o      = out_valid_o;
  assign in_ready_o  = !flush_i && ((state_q == EMPTY) || (out_ready_i && at_end));
  assign accept      = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = data_q[idx_q];
  assign out_last_o  = out_valid_o && last_q && at_end;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (accept) begin
      state_d = DRAIN;
      idx_d   = '0;
      load    = 1'b1;
    end else if (pop) begin
      if (at_end) begin
        state_d = EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IdxWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      lidx_q  <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        data_q <= in_data_i;
        lidx_q <= lidx_in;
        last_q <= in_last_i;
      end
    end
  end

endmodule

// File: tb/tb_fifo_unpack.sv
// Scoreboard bench for fifo_unpack: expected words queued at input handshake,
// popped and compared at every output handshake.
module tb_fifo_unpack;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [2:0]   in_cnt;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  fifo_unpack dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_cnt_i(in_cnt), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .busy_o(busy)
  );

  // output handshake monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got data=%h last=%b, expected no word", out_data, out_last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_data !== e.d || out_last !== e.l)
          $display("FAIL sb_word: got data=%h last=%b, expected data=%h last=%b",
                   out_data, out_last, e.d, e.l);
        else passed++;
      end
    end
  end

  task automatic push_exp(input logic [127:0] d, input logic [2:0] c, input logic l);
    int n;
    exp_t e;
    n = (c == 0 || c > 4) ? 4 : int'(c);
    for (int k = 0; k < n; k++) begin
      e.d = d[k*32 +: 32];
      e.l = l && (k == n-1);
      sb.push_back(e);
    end
  endtask

  // drive one beat, queue its words at the handshake, drop valid after the edge
  task automatic send_beat(input logic [127:0] d, input logic [2:0] c, input logic l);
    bit done = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_cnt = c; in_last = l;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(d, c, l);
        done = 1;
      end
    end
    checks++;
    if (!done) $display("FAIL send_timeout: got in_ready=0 for 40 cycles, expected 1");
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    checks++;
    if (!done) $display("FAIL drain_timeout: got %0d words pending valid=%b, expected 0", sb.size(), out_valid);
    else passed++;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset: got v=%b d=%h l=%b b=%b r=%b, expected 0 0 0 0 1",
               out_valid, out_data, out_last, busy, in_ready);
    else passed++;
  endtask

  task automatic test_full_beat();
    out_ready = 1'b1;
    send_beat(128'h44444444_33333333_22222222_11111111, 3'd4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== (k == 3) || busy !== 1'b1)
        $display("FAIL full_ready_w%0d: got in_ready=%b busy=%b, expected %b 1", k, in_ready, busy, k == 3);
      else passed++;
      if (k < 3) @(posedge clk);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_beat(128'h0000000d_0000000c_0000000b_0000000a, 3'd4, 1'b0);
    in_valid = 1'b1; in_data = 128'h000000a4_000000a3_000000a2_000000a1;
    in_cnt = 3'd4; in_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || (i < 4 && in_ready !== (i == 3)))
        $display("FAIL b2b_cycle%0d: got valid=%b in_ready=%b, expected 1 %b", i, out_valid, in_ready, i == 3);
      else passed++;
      if (i == 3) push_exp(in_data, in_cnt, in_last);
      @(posedge clk); #1;
      if (i == 3) in_valid = 1'b0;
    end
    wait_drain();
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    send_beat(128'h0000000d_0000000c_0000000b_0000000a, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ((k < 2 && in_ready !== (k == 1)) || out_valid !== (k < 2))
        $display("FAIL partial_c%0d: got in_ready=%b valid=%b, expected %b %b", k, in_ready, out_valid, k == 1, k < 2);
      else passed++;
      if (k < 2) @(posedge clk);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic        rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] pd;
    logic        pl, pstall;
    out_ready = 1'b0;
    send_beat(128'h00000044_00000033_00000022_00000011, 3'd4, 1'b1);
    pstall = 1'b0; pd = '0; pl = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (in_ready !== (i == 5) || (pstall && (out_data !== pd || out_last !== pl)))
        $display("FAIL bp_c%0d: got in_ready=%b d=%h l=%b, expected %b d=%h l=%b (stalled=%b)",
                 i, in_ready, out_data, out_last, i == 5, pd, pl, pstall);
      else passed++;
      pstall = out_valid && !out_ready; pd = out_data; pl = out_last;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send_beat(128'h000000f4_000000f3_000000f2_000000f1, 3'd4, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1;
    in_data = 128'h000000e4_000000e3_000000e2_000000e1; in_cnt = 3'd4; in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b, expected 0", in_ready);
    else passed++;
    @(posedge clk); #1;
    sb.delete();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_empty: got valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    else passed++;
    push_exp(in_data, in_cnt, in_last);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_clamp();
    out_ready = 1'b1;
    send_beat(128'h00000504_00000503_00000502_00000501, 3'd0, 1'b1);
    wait_drain();
    send_beat(128'h00000704_00000703_00000702_00000701, 3'd7, 1'b0);
    wait_drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_beat(128'h00000904_00000903_00000902_00000901, 3'd4, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid: got valid=%b busy=%b in_ready=%b, expected 0 0 1", out_valid, busy, in_ready);
    else passed++;
    sb.delete();
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL rst_after%0d: got valid=%b in_ready=%b, expected 0 1", i, out_valid, in_ready);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_cnt = '0; in_last = 1'b0; out_ready = 1'b0;
    #23;
    test_reset();
    rst_n = 1'b1;
    test_full_beat();
    test_back_to_back();
    test_partial();
    test_backpressure();
    test_flush();
    test_clamp();
    test_async_reset();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d words, expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
